// File: rtl/logic_unit_pipe.sv
// Logic unit (ORA/AND/EOR/BIT/TSB/TRB/pass) with a 2-entry registered output FIFO.
// Optional status flags are built only when LOGIC_UNIT_FLAGS_EN is defined.
module logic_unit_pipe #(
    parameter int DBW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     op,
    input  logic [DBW-1:0] a,
    input  logic [DBW-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DBW-1:0] o,
    output logic           flag_n,
    output logic           flag_v,
    output logic           flag_z
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t         state, state_nxt;
    logic           acc, con;
    logic           load_main, load_skid, skid_to_main;
    logic [DBW-1:0] ab, res;
    logic [DBW-1:0] main_d, skid_d;

    // in_ready depends only on held occupancy and reset, never on in_valid
    assign in_ready  = (state != FULL) && !rst;
    assign out_valid = (state != EMPTY);
    assign acc       = in_valid && in_ready;
    assign con       = out_valid && out_ready;
    assign o         = main_d;

    assign ab = a & b;

    always_comb begin
        res = b;
        case (op)
            3'd0:    res = a | b;
            3'd1:    res = ab;
            3'd2:    res = a ^ b;
            3'd3:    res = ab;
            3'd4:    res = a | b;
            3'd5:    res = ~a & b;
            default: res = b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state)
            EMPTY: if (acc) begin
                load_main = 1'b1;
                state_nxt = ONE;
            end
            ONE: begin
                if (acc && con) begin
                    load_main = 1'b1;
                end else if (acc) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (con) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: if (con) begin
                skid_to_main = 1'b1;
                state_nxt    = ONE;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_d <= '0;
            skid_d <= '0;
        end else begin
            if (load_main)         main_d <= res;
            else if (skid_to_main) main_d <= skid_d;
            if (load_skid)         skid_d <= res;
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    logic       test_op;
    logic [2:0] res_f, main_f, skid_f;

    // BIT/TSB/TRB report on the memory operand and the a&b test, not on the result
    assign test_op = (op == 3'd3) || (op == 3'd4) || (op == 3'd5);

    always_comb begin
        res_f[2] = test_op ? b[DBW-1] : res[DBW-1];
        res_f[1] = (op == 3'd3) ? b[DBW-2] : 1'b0;
        res_f[0] = test_op ? (ab == '0) : (res == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_f <= '0;
            skid_f <= '0;
        end else begin
            if (load_main)         main_f <= res_f;
            else if (skid_to_main) main_f <= skid_f;
            if (load_skid)         skid_f <= res_f;
        end
    end

    assign {flag_n, flag_v, flag_z} = main_f;
`else
    assign flag_n = 1'b0;
    assign flag_v = 1'b0;
    assign flag_z = 1'b0;
`endif
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (DBW=16); flag expectations follow LOGIC_UNIT_FLAGS_EN.
module tb_logic_unit_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  op;
    logic [15:0] a, b, o;
    logic        flag_n, flag_v, flag_z;
    int          checks = 0;
    int          errors = 0;

`ifdef LOGIC_UNIT_FLAGS_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic_unit_pipe #(.DBW(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .flag_n(flag_n), .flag_v(flag_v), .flag_z(flag_z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkf(input string tag, input logic n, input logic v, input logic z);
        logic [2:0] e;
        e = FE ? {n, v, z} : 3'b000;
        chk(tag, {29'd0, flag_n, flag_v, flag_z}, {29'd0, e});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o_, input logic [15:0] a_, input logic [15:0] b_);
        in_valid = 1'b1;
        op = o_;
        a = a_;
        b = b_;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_o", o, 0);
        chk("rst_flags", {flag_n, flag_v, flag_z}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // ORA, latency 1, single-cycle valid
        out_ready = 1'b1;
        drive(3'd0, 16'h00F0, 16'h0F00);
        tick(); in_valid = 1'b0;
        chk("ora_valid", out_valid, 1);
        chk("ora_o", o, 16'h0FF0);
        chkf("ora_flags", 0, 0, 0);
        tick();
        chk("ora_drained", out_valid, 0);

        // BIT
        drive(3'd3, 16'h00FF, 16'hC000);
        tick(); in_valid = 1'b0;
        chk("bit_o", o, 16'h0000);
        chkf("bit_flags", 1, 1, 1);
        tick();

        // TRB then TSB back to back
        drive(3'd5, 16'h000F, 16'h00FF);
        tick();
        drive(3'd4, 16'h0100, 16'h0001);
        chk("trb_o", o, 16'h00F0);
        chkf("trb_flags", 0, 0, 0);
        tick(); in_valid = 1'b0;
        chk("tsb_valid", out_valid, 1);
        chk("tsb_o", o, 16'h0101);
        chkf("tsb_flags", 0, 0, 1);
        tick();
        chk("tsb_drained", out_valid, 0);

        // backpressure: fill both entries, third op held off
        out_ready = 1'b0;
        drive(3'd0, 16'h0001, 16'h0002);
        tick();
        chk("bp1_in_ready", in_ready, 1);
        chk("bp1_o", o, 16'h0003);
        drive(3'd1, 16'h0003, 16'h0001);
        tick();
        chk("bp2_in_ready", in_ready, 0);
        chk("bp2_o", o, 16'h0003);
        drive(3'd2, 16'h0005, 16'h0005);
        tick();
        chk("bp3_ignored_ready", in_ready, 0);
        chk("bp3_hold_o", o, 16'h0003);
        chk("bp3_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("rel1_o", o, 16'h0001);
        chk("rel1_in_ready", in_ready, 1);
        chkf("rel1_flags", 0, 0, 0);
        tick(); in_valid = 1'b0;
        chk("rel2_o", o, 16'h0000);
        chkf("rel2_flags", 0, 0, 1);
        chk("rel2_valid", out_valid, 1);
        tick();
        chk("rel_drained", out_valid, 0);

        // sustained throughput, pass-b ops 6/7
        for (int i = 0; i < 8; i++) begin
            drive(3'd6 + 3'(i & 1), 16'hFFFF, 16'h8000 + 16'(i));
            tick();
            chk("thr_valid", out_valid, 1);
            chk("thr_ready", in_ready, 1);
            chk("thr_o", o, 16'h8000 + 16'(i));
            chkf("thr_flags", 1, 0, 0);
        end
        in_valid = 1'b0;
        tick();
        chk("thr_drained", out_valid, 0);

        // reset with two entries held and handshakes active
        out_ready = 1'b0;
        drive(3'd1, 16'hFFFF, 16'h1234);
        tick();
        drive(3'd2, 16'h00FF, 16'h0F0F);
        tick();
        chk("full_in_ready", in_ready, 0);
        chk("full_o", o, 16'h1234);
        rst = 1'b1; out_ready = 1'b1;
        tick();
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_o", o, 0);
        chk("rst2_in_ready", in_ready, 0);
        chk("rst2_flags", {flag_n, flag_v, flag_z}, 0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst2_release_ready", in_ready, 1);
        tick();
        chk("rst2_empty", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 SHALL have parameter DBW, default 16: operand and result width, any value >= 2.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: operation offered.
REQ-005 SHALL have port in_ready, output, 1: operation accepted when in_valid && in_ready at the clock edge.
REQ-006 SHALL have port op, input, 3: 0=ORA, 1=AND, 2=EOR, 3=BIT, 4=TSB, 5=TRB, 6/7=pass b.
REQ-007 SHALL have ports a and b, input, DBW each: a = accumulator operand, b = memory operand.
REQ-008 SHALL have port out_valid, output, 1: result available.
REQ-009 SHALL have port out_ready, input, 1: result consumed when out_valid && out_ready at the clock edge.
REQ-010 SHALL have port o, output, DBW: result.
REQ-011 SHALL have ports flag_n, flag_v, flag_z, output, 1 each: status flags for the result on o.

Function
REQ-012 Results SHALL be: ORA a|b; AND a&b; EOR a^b; BIT a&b; TSB a|b; TRB ~a&b; op 6/7 b.
REQ-013 flag_z SHALL be 1 when the result is 0 for ORA/AND/EOR/pass; for BIT/TSB/TRB, 1 when (a&b) is 0.
REQ-014 flag_n SHALL be result[DBW-1] for ORA/AND/EOR/pass, and b[DBW-1] for BIT/TSB/TRB.
REQ-015 flag_v SHALL be b[DBW-2] for BIT; for all other ops it is 0.
REQ-016 Result and flags SHALL be computed at acceptance and registered; o/flags become valid the cycle after acceptance (latency 1).
REQ-017 Storage SHALL be a 2-entry FIFO (main register plus skid register), delivered in acceptance order.
REQ-018 in_ready SHALL be 1 when fewer than 2 entries are held; it is a registered signal and never depends combinationally on in_valid.
REQ-019 With 1 entry held, simultaneous accept and consume SHALL keep occupancy 1, with the new entry becoming the head next cycle.
REQ-020 With 2 entries held, consume without accept SHALL move the skid entry to the head and raise in_ready the next cycle.
REQ-021 When out_valid && !out_ready, o and flags SHALL hold stable until consumed.
REQ-022 With sustained in_valid and out_ready, throughput SHALL be one operation per cycle.
REQ-023 in_valid while in_ready=0 SHALL be ignored without corrupting held entries.
REQ-024 States SHALL be EMPTY (0 entries), ONE (1 entry) and FULL (2 entries).
REQ-025 EMPTY SHALL go to ONE on accept.
REQ-026 ONE SHALL go to FULL on accept without consume, to EMPTY on consume without accept, and stay in ONE on both or neither.
REQ-027 FULL SHALL go to ONE on consume.

Reset
REQ-028 While rst=1, the block SHALL enter EMPTY with out_valid=0, in_ready=0, o=0 and all flags 0.
REQ-029 The first cycle after rst deasserts SHALL have in_ready=1.
REQ-030 Reset SHALL win over simultaneous handshakes; in-flight entries are discarded.

Configuration
REQ-031 With macro LOGIC_UNIT_FLAGS_EN defined, flags SHALL be computed and stored per REQ-013..015.
REQ-032 Without LOGIC_UNIT_FLAGS_EN, flag_n/flag_v/flag_z SHALL be constant 0 and no flag storage is built; data path and handshake timing are unchanged.

Verification (DBW=16, LOGIC_UNIT_FLAGS_EN defined unless stated)
REQ-033 SHALL cover: op=0, a=0x00F0, b=0x0F00, out_ready=1 -> next cycle o=0x0FF0, n=0, z=0, out_valid=1 for one cycle.
REQ-034 SHALL cover: op=3, a=0x00FF, b=0xC000 -> o=0x0000, z=1, n=1, v=1.
REQ-035 SHALL cover: op=5, a=0x000F, b=0x00FF -> o=0x00F0, z=0; then op=4, a=0x0100, b=0x0001 -> o=0x0101, z=1.
REQ-036 SHALL cover: out_ready=0, three back-to-back ops (ORA 1|2, AND 3&1, EOR 5^5) -> in_ready drops after two; on release results are 0x0003, 0x0001, 0x0000 (z=1) in order.
REQ-037 SHALL cover: continuous valid/ready for 8 cycles -> 8 results on 8 consecutive cycles; then rst asserted with 2 entries held -> out_valid=0 and o=0 on the next cycle.
REQ-038 SHALL cover: build without LOGIC_UNIT_FLAGS_EN, op=3, b=0xC000 -> all flags 0, o=a&b.
